// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU definitions: operation encodings, sequencer state encodings and
// small op-class helpers used by the E-stage multiply/divide sequencer.
package mdu_sequencer_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTLO  = 3'd4,
        MDU_MTHI  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } mdu_state_e;

    localparam int MDU_CYCLES_MIN = 2;
    localparam int MDU_CYCLES_MAX = 15;

    function automatic logic mdu_op_legal(input logic [2:0] op);
        return op <= MDU_MTHI;
    endfunction

    // Multi-cycle arithmetic (mult/multu/div/divu) versus single-cycle moves.
    function automatic logic mdu_op_is_arith(input logic [2:0] op);
        return !op[2];
    endfunction

    function automatic logic mdu_op_is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// E-stage sequencer for the multiply/divide unit: accepts one operation,
// launches the datapath, times it with a down-counter and pulses the HI/LO commit.
//
// state  | meaning
// IDLE   | ready; mtlo/mthi complete from here via mv_pend
// RUN    | arithmetic op in flight, counter counting down to 1
// COMMIT | datapath writes HI/LO this cycle; new requests wait
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        rd_req,
    input  logic        flush,
    output logic        req_ready,
    output logic        stall,
    output logic        mdu_start,
    output logic [2:0]  mdu_ctrl,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    output logic        mdu_commit,
    output logic        busy,
    output logic        will_busy
);

    if (MULT_CYCLES < MDU_CYCLES_MIN || MULT_CYCLES > MDU_CYCLES_MAX) begin : g_bad_mult_cycles
        $error("mdu_sequencer: MULT_CYCLES must be within 2..15");
    end
    if (DIV_CYCLES < MDU_CYCLES_MIN || DIV_CYCLES > MDU_CYCLES_MAX) begin : g_bad_div_cycles
        $error("mdu_sequencer: DIV_CYCLES must be within 2..15");
    end

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mv_pend_q, mv_pend_d;
    logic        start_q, start_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic        busy_w;
    logic        accept;
    logic        accept_arith;
    logic        accept_mv;

    always_comb begin
        busy_w       = (state_q != ST_IDLE);
        // Reset gating keeps will_busy and the latches quiet while reset is held.
        accept       = reset && req_valid && !flush && mdu_op_legal(req_op)
                       && (state_q == ST_IDLE);
        accept_arith = accept && mdu_op_is_arith(req_op);
        accept_mv    = accept && !mdu_op_is_arith(req_op);

        state_d   = state_q;
        cnt_d     = cnt_q;
        mv_pend_d = accept_mv;
        start_d   = accept;
        ctrl_d    = ctrl_q;
        a_d       = a_q;
        b_d       = b_q;

        if (accept) begin
            ctrl_d = req_op;
            a_d    = req_a;
            b_d    = req_b;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_arith) begin
                    cnt_d   = mdu_op_is_div(req_op) ? DIV_LOAD : MULT_LOAD;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            mv_pend_q <= 1'b0;
            start_q   <= 1'b0;
            ctrl_q    <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mv_pend_q <= mv_pend_d;
            start_q   <= start_d;
            ctrl_q    <= ctrl_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign busy       = busy_w;
    assign req_ready  = !busy_w;
    assign will_busy  = accept_arith || (state_q == ST_RUN);
    assign stall      = (req_valid && busy_w) || (rd_req && (busy_w || mv_pend_q));
    assign mdu_start  = start_q;
    assign mdu_commit = (state_q == ST_COMMIT) || mv_pend_q;
    assign mdu_ctrl   = ctrl_q;
    assign mdu_a      = a_q;
    assign mdu_b      = b_q;

endmodule
